// File: rtl/data_mem_lsu.sv
// Load/store initiator for the byte-banked data memory: legality check, byte-enable generation,
// load extraction with sign/zero extension, and a one-cycle response strobe.
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | address/write-enables presented; store writes here
//   LDATA  | read data on mem_Dataout, captured at end of cycle
//   RESP   | response strobe
module data_mem_lsu #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_Datain1,
    output logic [31:0] mem_Datain2,
    output logic [3:0]  mem_Wr,
    output logic        mem_enable_load_ex_mem,
    input  logic [31:0] mem_Dataout
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LDATA  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [12:0] LP_LAST = 13'(MEM_BYTES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr_q;
    logic [31:0] r_wdata_q;
    logic [31:0] r_rdata_q;
    logic [1:0]  r_size_q;
    logic        r_we_q;
    logic        r_uns_q;
    logic        r_err_q;

    logic        w_accept;
    logic        w_illegal;
    logic [12:0] w_nbytes;
    logic [12:0] w_end;
    logic [31:0] w_wdata_m;
    logic [31:0] w_ldata;
    logic [3:0]  w_wr_mask;

    assign req_ready = (r_state == IDLE) && !Reset;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_nbytes  = 13'd4;
        w_wdata_m = req_wdata;
        case (req_size)
            2'd0: begin
                w_nbytes  = 13'd1;
                w_wdata_m = {24'd0, req_wdata[7:0]};
            end
            2'd1: begin
                w_nbytes  = 13'd2;
                w_wdata_m = {16'd0, req_wdata[15:0]};
            end
            default: ;
        endcase
    end

    // 13-bit end address so an access straddling the top of the array cannot wrap to a small value
    assign w_end     = {1'b0, req_addr[11:0]} + w_nbytes - 13'd1;
    assign w_illegal = (req_size == 2'd3) || (req_addr[31:12] != 20'd0) || (w_end > LP_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_illegal ? RESP : ACCESS;
            ACCESS:  w_next = r_we_q ? RESP : LDATA;
            LDATA:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_wr_mask = 4'b1111;
        w_ldata   = mem_Dataout;
        case (r_size_q)
            2'd0: begin
                w_wr_mask = 4'b0001;
                w_ldata   = {{24{mem_Dataout[7] & !r_uns_q}}, mem_Dataout[7:0]};
            end
            2'd1: begin
                w_wr_mask = 4'b0011;
                w_ldata   = {{16{mem_Dataout[15] & !r_uns_q}}, mem_Dataout[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_addr_q  <= 32'd0;
            r_wdata_q <= 32'd0;
            r_rdata_q <= 32'd0;
            r_size_q  <= 2'd0;
            r_we_q    <= 1'b0;
            r_uns_q   <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr_q  <= req_addr;
                r_wdata_q <= w_wdata_m;
                r_size_q  <= req_size;
                r_we_q    <= req_we;
                r_uns_q   <= req_unsigned;
                r_err_q   <= w_illegal;
            end
            if (r_state == LDATA) r_rdata_q <= w_ldata;
        end
    end

    // Reset gates the enables combinationally so an abort in ACCESS never writes
    assign mem_Wr = ((r_state == ACCESS) && r_we_q && !r_err_q && !Reset) ? w_wr_mask : 4'b0000;
    assign mem_address            = r_addr_q;
    assign mem_Datain1            = r_wdata_q;
    assign mem_Datain2            = 32'd0;
    assign mem_enable_load_ex_mem = 1'b0;

    assign resp_valid = (r_state == RESP);
    assign resp_err   = (r_state == RESP) && r_err_q;
    assign resp_rdata = ((r_state == RESP) && !r_we_q && !r_err_q) ? r_rdata_q : 32'd0;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a byte-rotating synchronous-read memory model.
module tb_data_mem_lsu;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_Datain1;
    logic [31:0] mem_Datain2;
    logic [3:0]  mem_Wr;
    logic        mem_enable_load_ex_mem;
    logic [31:0] mem_Dataout;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    data_mem_lsu #(.MEM_BYTES(4096)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_Datain1(mem_Datain1), .mem_Datain2(mem_Datain2),
        .mem_Wr(mem_Wr), .mem_enable_load_ex_mem(mem_enable_load_ex_mem),
        .mem_Dataout(mem_Dataout)
    );

    // memory model: byte at mem_address lives on lane 0, reads one cycle late
    logic [7:0]  mem [0:4095];
    logic [31:0] r_dout;
    logic [11:0] a0, a1, a2, a3;
    assign a0 = mem_address[11:0];
    assign a1 = a0 + 12'd1;
    assign a2 = a0 + 12'd2;
    assign a3 = a0 + 12'd3;
    assign mem_Dataout = r_dout;

    always @(posedge Clk) begin
        if (mem_Wr[0]) mem[a0] <= mem_Datain1[7:0];
        if (mem_Wr[1]) mem[a1] <= mem_Datain1[15:8];
        if (mem_Wr[2]) mem[a2] <= mem_Datain1[23:16];
        if (mem_Wr[3]) mem[a3] <= mem_Datain1[31:24];
        r_dout <= {mem[a3], mem[a2], mem[a1], mem[a0]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 10) begin
            step();
            n++;
        end
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // one transaction; exp_lat counts cycles after the accept edge until resp_valid
    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [3:0] exp_wr, input logic [31:0] exp_din, input int exp_lat);
        int lat;
        int wr_cycles;
        logic [3:0]  wr_seen;
        logic [31:0] din_seen;
        logic        got;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        wait_ready(tag);
        step();
        req_valid = 1'b0;
        lat = 0; wr_cycles = 0; wr_seen = 4'd0; din_seen = 32'd0; got = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_Wr != 4'd0) begin
                wr_cycles++;
                wr_seen  = wr_seen | mem_Wr;
                din_seen = mem_Datain1;
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
                break;
            end
            step();
        end
        check_eq({tag, "_resp_seen"}, {31'd0, got}, 32'd1);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
        check_eq({tag, "_wr"}, {28'd0, wr_seen}, {28'd0, exp_wr});
        check_eq({tag, "_wr_cycles"}, wr_cycles, (exp_wr != 4'd0) ? 1 : 0);
        if (exp_wr != 4'd0) check_eq({tag, "_datain1"}, din_seen, exp_din);
        step();
        check_eq({tag, "_resp_drop"}, {31'd0, resp_valid}, 32'd0);
        check_eq({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        step();
        step();
        check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_addr", mem_address, 32'd0);
        check_eq("rst_din", mem_Datain1, 32'd0);
        check_eq("rst_wr", {28'd0, mem_Wr}, 32'd0);
        check_eq("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("tie_din2", mem_Datain2, 32'd0);
        check_eq("tie_init", {31'd0, mem_enable_load_ex_mem}, 32'd0);
        Reset = 1'b0;
        #1;
        check_eq("rst_ready_after", {31'd0, req_ready}, 32'd1);

        //    tag        we    sz    uns   addr           wdata          rdata          err   wr       din            lat
        xact("st_w10",   1'b1, 2'd2, 1'b0, 32'h010,       32'hDEADBEEF,  32'h0,         1'b0, 4'b1111, 32'hDEADBEEF,  2);
        xact("ld_w10",   1'b0, 2'd2, 1'b0, 32'h010,       32'h0,         32'hDEADBEEF,  1'b0, 4'b0000, 32'h0,         3);
        xact("ld_b11s",  1'b0, 2'd0, 1'b0, 32'h011,       32'h0,         32'hFFFFFFBE,  1'b0, 4'b0000, 32'h0,         3);
        xact("ld_b11u",  1'b0, 2'd0, 1'b1, 32'h011,       32'h0,         32'h000000BE,  1'b0, 4'b0000, 32'h0,         3);
        xact("ld_h12s",  1'b0, 2'd1, 1'b0, 32'h012,       32'h0,         32'hFFFFDEAD,  1'b0, 4'b0000, 32'h0,         3);
        xact("st_h13",   1'b1, 2'd1, 1'b0, 32'h013,       32'hABCD1234,  32'h0,         1'b0, 4'b0011, 32'h00001234,  2);
        xact("ld_h13u",  1'b0, 2'd1, 1'b1, 32'h013,       32'h0,         32'h00001234,  1'b0, 4'b0000, 32'h0,         3);
        xact("ld_b10u",  1'b0, 2'd0, 1'b1, 32'h010,       32'h0,         32'h000000EF,  1'b0, 4'b0000, 32'h0,         3);
        xact("ld_b12u",  1'b0, 2'd0, 1'b1, 32'h012,       32'h0,         32'h000000AD,  1'b0, 4'b0000, 32'h0,         3);
        xact("st_wffc",  1'b1, 2'd2, 1'b0, 32'hFFC,       32'hA5A55A5A,  32'h0,         1'b0, 4'b1111, 32'hA5A55A5A,  2);
        xact("ld_wffc",  1'b0, 2'd2, 1'b0, 32'hFFC,       32'h0,         32'hA5A55A5A,  1'b0, 4'b0000, 32'h0,         3);
        xact("ld_bfffs", 1'b0, 2'd0, 1'b0, 32'hFFF,       32'h0,         32'hFFFFFFA5,  1'b0, 4'b0000, 32'h0,         3);
        xact("il_wffd",  1'b0, 2'd2, 1'b0, 32'hFFD,       32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         1);
        xact("il_hfff",  1'b1, 2'd1, 1'b0, 32'hFFF,       32'h1111,      32'h0,         1'b1, 4'b0000, 32'h0,         1);
        xact("il_s1000", 1'b1, 2'd2, 1'b0, 32'h1000,      32'h12345678,  32'h0,         1'b1, 4'b0000, 32'h0,         1);
        xact("il_size3", 1'b0, 2'd3, 1'b0, 32'h000,       32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         1);
        xact("il_hiadr", 1'b0, 2'd0, 1'b0, 32'h80000010,  32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         1);
        xact("st_w20",   1'b1, 2'd2, 1'b0, 32'h020,       32'h11223344,  32'h0,         1'b0, 4'b1111, 32'h11223344,  2);

        // back-to-back: requester holds a second request while the first load is in flight
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h010; req_wdata = 32'h0;
        wait_ready("b2b_first");
        step();
        req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h014;
        for (int c = 1; c <= 3; c++) begin
            check_eq($sformatf("b2b_ready_low_c%0d", c), {31'd0, req_ready}, 32'd0);
            check_eq($sformatf("b2b_addr_c%0d", c), mem_address, 32'h010);
            if (c == 3) begin
                check_eq("b2b_resp1", {31'd0, resp_valid}, 32'd1);
                check_eq("b2b_rdata1", resp_rdata, 32'h34ADBEEF);
            end else begin
                step();
            end
        end
        step();
        check_eq("b2b_ready_back", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check_eq("b2b_accept2_addr", mem_address, 32'h014);
        step();
        step();
        check_eq("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        check_eq("b2b_rdata2", resp_rdata, 32'h00000012);
        step();

        // reset aborting a word store while in ACCESS
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h020; req_wdata = 32'hCAFEF00D;
        wait_ready("abort");
        step();
        req_valid = 1'b0;
        check_eq("abort_wr_pre", {28'd0, mem_Wr}, 32'hF);
        Reset = 1'b1;
        #1;
        check_eq("abort_wr_forced", {28'd0, mem_Wr}, 32'd0);
        check_eq("abort_ready_in_rst", {31'd0, req_ready}, 32'd0);
        step();
        Reset = 1'b0;
        #1;
        check_eq("abort_ready_after", {31'd0, req_ready}, 32'd1);
        begin
            logic any_resp;
            any_resp = 1'b0;
            for (int c = 0; c < 4; c++) begin
                any_resp = any_resp | resp_valid;
                step();
            end
            check_eq("abort_no_resp", {31'd0, any_resp}, 32'd0);
        end
        xact("ld_w20",   1'b0, 2'd2, 1'b0, 32'h020,       32'h0,         32'h11223344,  1'b0, 4'b0000, 32'h0,         3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
